// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] WORD_BYTES    = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch buffer of fetched {instr, pc} entries with synchronous flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           push,
  input  fetch_entry_t                   wr_entry,
  input  logic                           pop,
  output fetch_entry_t                   head_entry,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;
  fetch_entry_t  mem [DEPTH];

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full queue accepts a new word only when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_pop)  head_q <= head_q + PW'(1);
      if (do_push) tail_q <= tail_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[tail_q] <= wr_entry;
  end

  assign head_entry = mem[head_q];
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, imem addressing, and prefetch queue toward decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rd,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       instr_valid,
  output logic [31:0]                instr,
  output logic [31:0]                instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  logic [31:0]  pc_q;
  logic         pop;
  logic         push;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t wr_entry;
  fetch_entry_t head_entry;

  assign pop      = instr_valid & instr_ready;
  // Redirect wins: the word at the old PC is stale and must not enter the queue.
  assign push     = ~redirect_valid & (~q_full | pop);
  assign wr_entry = '{instr: imem_rd, pc: pc_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              pc_q <= RESET_PC & PC_ALIGN_MASK;
    else if (redirect_valid) pc_q <= redirect_pc & PC_ALIGN_MASK;
    else if (push)           pc_q <= pc_q + WORD_BYTES;
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .wr_entry   (wr_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (occupancy),
    .empty      (q_empty),
    .full       (q_full)
  );

  assign imem_addr   = pc_q;
  assign instr_valid = ~q_empty;
  assign instr       = q_empty ? '0 : head_entry.instr;
  assign instr_pc    = q_empty ? '0 : head_entry.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed phases push expected pops, a monitor compares.
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  occupancy;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Memory image: word[i] = i.
  assign imem_rd = {2'b00, imem_addr[31:2]};

  instr_fetch #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .occupancy      (occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] i, input logic [31:0] p);
    sb.push_back('{instr: i, pc: p});
  endtask

  // Monitor: every completed handshake must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset && instr_valid && instr_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pop actual_pc=%h actual_instr=%h expected=none", instr_pc, instr);
        end else begin
          e = sb.pop_front();
          if (instr !== e.instr || instr_pc !== e.pc) begin
            failures++;
            $display("FAIL pop actual=%h/%h expected=%h/%h", instr_pc, instr, e.pc, e.instr);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #12;
    chk("rst_occ",   32'(occupancy), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc",    instr_pc, 32'd0);
    chk("rst_addr",  imem_addr, 32'd0);

    // Streaming from reset with decode always ready.
    @(negedge clk);
    exp_push(32'd0, 32'h00); exp_push(32'd1, 32'h04); exp_push(32'd2, 32'h08);
    exp_push(32'd3, 32'h0C); exp_push(32'd4, 32'h10);
    reset = 1'b1; instr_ready = 1'b1;
    chk("valid_before_edge", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("valid_after_edge", 32'(instr_valid), 32'd1);
    chk("first_pc", instr_pc, 32'h0);
    chk("stream_occ", 32'(occupancy), 32'd1);
    repeat (5) @(negedge clk);
    instr_ready = 1'b0;

    // Decode stall: queue saturates, PC holds.
    repeat (10) @(negedge clk);
    chk("stall_occ", 32'(occupancy), 32'd4);
    chk("stall_addr", imem_addr, 32'h24);
    @(negedge clk);
    chk("stall_addr_hold", imem_addr, 32'h24);
    chk("stall_head", instr_pc, 32'h14);

    // Full queue with simultaneous pop and push.
    exp_push(32'h05, 32'h14); exp_push(32'h06, 32'h18); exp_push(32'h07, 32'h1C);
    instr_ready = 1'b1;
    @(negedge clk);
    chk("full_pp_occ1", 32'(occupancy), 32'd4);
    chk("full_pp_addr1", imem_addr, 32'h28);
    @(negedge clk);
    chk("full_pp_occ2", 32'(occupancy), 32'd4);
    chk("full_pp_addr2", imem_addr, 32'h2C);
    @(negedge clk);
    instr_ready = 1'b0;
    chk("full_pp_occ3", 32'(occupancy), 32'd4);
    chk("full_pp_addr3", imem_addr, 32'h30);

    // Redirect to 0x100, let three entries accumulate.
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rd1_occ", 32'(occupancy), 32'd0);
    chk("rd1_addr", imem_addr, 32'h100);
    chk("rd1_valid", 32'(instr_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("rd1_fill3", 32'(occupancy), 32'd3);

    // Unaligned redirect with a handshake in the same cycle.
    exp_push(32'h40, 32'h100);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043; instr_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rd2_occ", 32'(occupancy), 32'd0);
    chk("rd2_addr", imem_addr, 32'h40);
    chk("rd2_valid", 32'(instr_valid), 32'd0);
    exp_push(32'h10, 32'h40);
    @(negedge clk);
    chk("rd2_target_valid", 32'(instr_valid), 32'd1);
    chk("rd2_target_pc", instr_pc, 32'h40);
    @(negedge clk);
    instr_ready = 1'b0;

    // Redirect to the top word: PC wraps to zero.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    exp_push(32'h3FFF_FFFF, 32'hFFFF_FFFC); exp_push(32'd0, 32'h0); exp_push(32'd1, 32'h4);
    instr_ready = 1'b1;
    @(negedge clk);
    chk("wrap_addr_zero", imem_addr, 32'h0);
    repeat (3) @(negedge clk);
    instr_ready = 1'b0;

    // Asynchronous reset between edges with a full queue.
    repeat (5) @(negedge clk);
    chk("prerst_occ", 32'(occupancy), 32'd4);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_occ",   32'(occupancy), 32'd0);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_pc",    instr_pc, 32'd0);
    chk("arst_addr",  imem_addr, 32'd0);
    @(negedge clk);
    exp_push(32'd0, 32'h0); exp_push(32'd1, 32'h4); exp_push(32'd2, 32'h8);
    reset = 1'b1; instr_ready = 1'b1;
    repeat (4) @(negedge clk);
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
